// File: rtl/retire_rat_pkg.sv
// Shared rename constants and the restore FSM state type used by the retirement RAT.
package rv32i_types;
  localparam int ARCH_REG_NUM = 32;
  localparam int PHYS_REG_NUM = 64;
  localparam int PR_WIDTH     = $clog2(PHYS_REG_NUM);

  typedef enum logic {
    RRAT_IDLE,
    RRAT_RESTORE
  } rrat_state_t;
endpackage

// File: rtl/retire_rat_if.sv
// Commit, free-list and front-RAT restore bundle between the ROB side and the retirement RAT.
interface retire_rat_if
  import rv32i_types::*;
#(
  parameter int RESTORE_LANES = 4
) ();
  logic                              commit_valid;
  logic                              commit_ready;
  logic [4:0]                        commit_arch_rd;
  logic [PR_WIDTH-1:0]               commit_phys_rd;
  logic                              commit_flush;
  logic                              commit_is_jmp;
  logic                              fl_enqueue;
  logic                              fl_jmp;
  logic                              fl_branch;
  logic [PR_WIDTH-1:0]               fl_freed_phys_reg;
  logic                              restore_valid;
  logic [4:0]                        restore_base;
  logic [RESTORE_LANES*PR_WIDTH-1:0] restore_phys;
  logic                              restore_busy;

  modport master (
    output commit_valid, commit_arch_rd, commit_phys_rd, commit_flush, commit_is_jmp,
    input  commit_ready, fl_enqueue, fl_jmp, fl_branch, fl_freed_phys_reg,
    input  restore_valid, restore_base, restore_phys, restore_busy
  );

  modport slave (
    input  commit_valid, commit_arch_rd, commit_phys_rd, commit_flush, commit_is_jmp,
    output commit_ready, fl_enqueue, fl_jmp, fl_branch, fl_freed_phys_reg,
    output restore_valid, restore_base, restore_phys, restore_busy
  );
endinterface

// File: rtl/retire_rat_restore_seq.sv
// Restore sequencer: walks the committed map to the front RAT in fixed-size beats after a flush.
module rrat_restore_seq
  import rv32i_types::*;
#(
  parameter int RESTORE_LANES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       commit_ready,
  output logic       restore_valid,
  output logic       restore_busy,
  output logic [4:0] restore_base
);
  localparam int BEATS  = ARCH_REG_NUM / RESTORE_LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  rrat_state_t       state, state_n;
  logic [BEAT_W-1:0] beat, beat_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RRAT_IDLE;
      beat  <= '0;
    end else begin
      state <= state_n;
      beat  <= beat_n;
    end
  end

  always_comb begin
    state_n = state;
    beat_n  = beat;
    case (state)
      RRAT_IDLE: begin
        if (start) begin
          state_n = RRAT_RESTORE;
          beat_n  = '0;
        end
      end
      RRAT_RESTORE: begin
        if (beat == LAST_BEAT) begin
          state_n = RRAT_IDLE;
          beat_n  = '0;
        end else begin
          beat_n = beat + 1'b1;
        end
      end
      default: begin
        state_n = RRAT_IDLE;
        beat_n  = '0;
      end
    endcase
  end

  assign commit_ready  = (state == RRAT_IDLE);
  assign restore_valid = (state == RRAT_RESTORE);
  assign restore_busy  = (state == RRAT_RESTORE);
  // beat is zero in IDLE, so the base idles at 0 as well
  assign restore_base  = 5'(int'(beat) * RESTORE_LANES);
endmodule

// File: rtl/retire_rat.sv
// Retirement RAT: records committed arch->phys mappings, frees superseded registers, restores on flush.
// Optional RRAT_SCOREBOARD_EN adds a phys in-use vector and a sticky protocol-error flag.
module retire_rat
  import rv32i_types::*;
#(
  parameter int RESTORE_LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  retire_rat_if.slave  bus
`ifdef RRAT_SCOREBOARD_EN
  ,
  output logic         err_sticky
`endif
);
  logic [PR_WIDTH-1:0] rrat [ARCH_REG_NUM];
  logic                accept;
  logic                start_restore;
  logic                rd_nz;
  logic                wr_en;
  logic [PR_WIDTH-1:0] old_phys;

  assign accept        = bus.commit_valid && bus.commit_ready;
  assign rd_nz         = (bus.commit_arch_rd != 5'd0);
  assign old_phys      = rrat[bus.commit_arch_rd];
  // branch flushes discard the committing destination; jumps keep it
  assign wr_en         = accept && rd_nz && (!bus.commit_flush || bus.commit_is_jmp);
  assign start_restore = accept && bus.commit_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REG_NUM; i++) rrat[i] <= PR_WIDTH'(i);
    end else if (wr_en) begin
      rrat[bus.commit_arch_rd] <= bus.commit_phys_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.fl_enqueue        <= 1'b0;
      bus.fl_jmp            <= 1'b0;
      bus.fl_branch         <= 1'b0;
      bus.fl_freed_phys_reg <= '0;
    end else begin
      bus.fl_enqueue        <= accept && !bus.commit_flush && rd_nz;
      bus.fl_jmp            <= accept && bus.commit_flush && bus.commit_is_jmp;
      bus.fl_branch         <= accept && bus.commit_flush && !bus.commit_is_jmp;
      // 0 doubles as the free-list x0 sentinel when nothing is actually freed
      bus.fl_freed_phys_reg <= wr_en ? old_phys : '0;
    end
  end

  rrat_restore_seq #(
    .RESTORE_LANES(RESTORE_LANES)
  ) u_seq (
    .clk          (clk),
    .rst          (rst),
    .start        (start_restore),
    .commit_ready (bus.commit_ready),
    .restore_valid(bus.restore_valid),
    .restore_busy (bus.restore_busy),
    .restore_base (bus.restore_base)
  );

  for (genvar k = 0; k < RESTORE_LANES; k++) begin : g_lane
    logic [4:0] idx;
    assign idx = bus.restore_base + 5'(k);
    assign bus.restore_phys[k*PR_WIDTH +: PR_WIDTH] = bus.restore_valid ? rrat[idx] : '0;
  end

`ifdef RRAT_SCOREBOARD_EN
  logic [PHYS_REG_NUM-1:0] in_use;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_use     <= {{(PHYS_REG_NUM-ARCH_REG_NUM){1'b0}}, {ARCH_REG_NUM{1'b1}}};
      err_sticky <= 1'b0;
    end else if (wr_en) begin
      // clear before set so a same-register rewrite stays marked in use
      in_use[old_phys]           <= 1'b0;
      in_use[bus.commit_phys_rd] <= 1'b1;
      if (in_use[bus.commit_phys_rd] || !in_use[old_phys]) err_sticky <= 1'b1;
    end
  end
`endif
endmodule
